// File: rtl/dmem_bus_bridge.sv
// rtl/dmem_bus_bridge.sv - core data strobes to valid/ready word bus bridge with lane alignment
// Optional response timeout: define DMEM_BRIDGE_TIMEOUT_EN.
module dmem_bus_bridge #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r,
  input  logic [3:0]        mem_w,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_dw,
  output logic [31:0]       mem_dr,
  output logic              stall,
  output logic              err,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_we,
  output logic [3:0]        bus_be,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_rsp_valid,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_off;
  logic              r_bus_req_valid;
  logic              r_bus_we;
  logic [3:0]        r_bus_be;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [31:0]       r_bus_wdata;
  logic [31:0]       r_mem_dr;
  logic              r_err;

  logic              w_is_write;
  logic              w_req;
  logic [1:0]        w_off;
  logic [7:0]        w_be_sh;
  logic              w_misaligned;
  logic              w_start;
  logic              w_rsp_take;
  logic              w_timeout;
  logic              w_to_hit;
  logic              w_accept;

  assign w_is_write   = (mem_w != 4'b0000);
  assign w_req        = mem_r | w_is_write;
  assign w_off        = mem_addr[1:0];
  // Widened shift so lanes pushed past byte 3 remain visible for the misalignment test.
  assign w_be_sh      = {4'b0000, mem_w} << w_off;
  assign w_misaligned = w_is_write && (w_be_sh[7:4] != 4'b0000);
  assign w_accept     = (r_state == REQ) && bus_req_ready;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  logic [15:0] r_to_cnt;

  assign w_to_hit = (r_to_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (w_accept) begin
      r_to_cnt <= '0;
    end else if (r_state == WAIT_RSP) begin
      r_to_cnt <= r_to_cnt + 16'd1;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign w_to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    stall      = 1'b0;
    w_start    = 1'b0;
    w_rsp_take = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req && !w_misaligned) begin
          stall   = 1'b1;
          w_start = 1'b1;
          w_next  = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus_req_ready) begin
          w_next = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        stall = 1'b1;
        // A response on the limit cycle takes priority over the timeout.
        if (bus_rsp_valid) begin
          w_rsp_take = 1'b1;
          w_next     = DONE;
        end else if (w_to_hit) begin
          w_timeout = 1'b1;
          w_next    = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_off           <= 2'b00;
      r_bus_req_valid <= 1'b0;
      r_bus_we        <= 1'b0;
      r_bus_be        <= 4'b0000;
      r_bus_addr      <= '0;
      r_bus_wdata     <= '0;
      r_mem_dr        <= '0;
      r_err           <= 1'b0;
    end else begin
      r_err <= (r_state == IDLE) && w_misaligned;
      if (w_start) begin
        r_off           <= w_off;
        r_bus_req_valid <= 1'b1;
        r_bus_we        <= w_is_write;
        r_bus_be        <= w_is_write ? w_be_sh[3:0] : 4'b1111;
        r_bus_addr      <= {mem_addr[ADDR_W-1:2], 2'b00};
        r_bus_wdata     <= mem_dw << {w_off, 3'b000};
      end
      if (w_accept) begin
        r_bus_req_valid <= 1'b0;
      end
      if (w_rsp_take && !r_bus_we) begin
        r_mem_dr <= bus_rdata >> {r_off, 3'b000};
      end
      if (w_timeout) begin
        r_mem_dr <= '0;
        r_err    <= 1'b1;
      end
    end
  end

  assign mem_dr        = r_mem_dr;
  assign err           = r_err;
  assign bus_req_valid = r_bus_req_valid;
  assign bus_we        = r_bus_we;
  assign bus_be        = r_bus_be;
  assign bus_addr      = r_bus_addr;
  assign bus_wdata     = r_bus_wdata;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// tb/tb_dmem_bus_bridge.sv - directed table-driven bench for dmem_bus_bridge
module tb_dmem_bus_bridge;

  logic        clk;
  logic        rst;
  logic        mem_r;
  logic [3:0]  mem_w;
  logic [31:0] mem_addr;
  logic [31:0] mem_dw;
  logic [31:0] mem_dr;
  logic        stall;
  logic        err;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_rsp_valid;
  logic [31:0] bus_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_bus_bridge #(.ADDR_W(32), .TIMEOUT_CYCLES(255)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_r        (mem_r),
    .mem_w        (mem_w),
    .mem_addr     (mem_addr),
    .mem_dw       (mem_dw),
    .mem_dr       (mem_dr),
    .stall        (stall),
    .err          (err),
    .bus_req_valid(bus_req_valid),
    .bus_req_ready(bus_req_ready),
    .bus_we       (bus_we),
    .bus_be       (bus_be),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rsp_valid(bus_rsp_valid),
    .bus_rdata    (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        rd;
    logic [3:0]  wr;
    logic [31:0] addr;
    logic [31:0] dw;
    logic [31:0] rdata;
    int          dly;
    logic [3:0]  be;
    logic [31:0] baddr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] dr;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_core();
    mem_r    = 1'b0;
    mem_w    = 4'b0000;
    mem_addr = 32'h0;
    mem_dw   = 32'h0;
  endtask

  task automatic run_vec(input int i);
    int stalls;
    vec_t v;
    v = vecs[i];
    stalls = 0;
    mem_r = v.rd; mem_w = v.wr; mem_addr = v.addr; mem_dw = v.dw;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = 32'hFFFF_FFFF;
    #1;
    if (stall) stalls++;
    tick();
    for (int k = 0; k <= v.dly; k++) begin
      #1;
      chk($sformatf("v%0d valid c%0d", i, k), 32'(bus_req_valid), 32'd1);
      chk($sformatf("v%0d addr c%0d", i, k), bus_addr, v.baddr);
      chk($sformatf("v%0d be c%0d", i, k), 32'(bus_be), 32'(v.be));
      chk($sformatf("v%0d wdata c%0d", i, k), bus_wdata, v.wdata);
      chk($sformatf("v%0d we c%0d", i, k), 32'(bus_we), 32'(v.we));
      if (stall) stalls++;
      if (k == v.dly) bus_req_ready = 1'b1;
      tick();
    end
    bus_req_ready = 1'b0;
    #1;
    chk($sformatf("v%0d valid dropped", i), 32'(bus_req_valid), 32'd0);
    if (stall) stalls++;
    bus_rsp_valid = 1'b1;
    bus_rdata = v.rdata;
    tick();
    bus_rsp_valid = 1'b0;
    bus_rdata = 32'hFFFF_FFFF;
    #1;
    chk($sformatf("v%0d done stall", i), 32'(stall), 32'd0);
    chk($sformatf("v%0d done dr", i), mem_dr, v.dr);
    chk($sformatf("v%0d done err", i), 32'(err), 32'd0);
    chk($sformatf("v%0d stall cycles", i), 32'(stalls), 32'(3 + v.dly));
    clear_core();
    tick();
  endtask

  task automatic run_misaligned(input string name, input logic [3:0] w, input logic [31:0] a);
    mem_r = 1'b0; mem_w = w; mem_addr = a; mem_dw = 32'h0000_1234;
    #1;
    chk({name, " stall"}, 32'(stall), 32'd0);
    tick();
    #1;
    chk({name, " err pulse"}, 32'(err), 32'd1);
    chk({name, " no valid"}, 32'(bus_req_valid), 32'd0);
    clear_core();
    tick();
    #1;
    chk({name, " err cleared"}, 32'(err), 32'd0);
    chk({name, " idle stall"}, 32'(stall), 32'd0);
  endtask

  initial begin
    //            rd    wr       addr          dw            rdata         dly be       baddr         wdata         we    dr
    vecs[0] = '{1'b0, 4'b1111, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0, 4'b1111, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000};
    vecs[1] = '{1'b0, 4'b0001, 32'h0000_0203, 32'h0000_00AB, 32'h0,        0, 4'b1000, 32'h0000_0200, 32'hAB00_0000, 1'b1, 32'h0000_0000};
    vecs[2] = '{1'b1, 4'b0000, 32'h0000_0302, 32'h0,        32'h1234_5678, 4, 4'b1111, 32'h0000_0300, 32'h0000_0000, 1'b0, 32'h0000_1234};
    vecs[3] = '{1'b0, 4'b0011, 32'h0000_0402, 32'h0000_CAFE, 32'h0,        2, 4'b1100, 32'h0000_0400, 32'hCAFE_0000, 1'b1, 32'h0000_1234};
    vecs[4] = '{1'b1, 4'b0000, 32'h0000_0500, 32'h0,        32'hA5A5_1234, 1, 4'b1111, 32'h0000_0500, 32'h0000_0000, 1'b0, 32'hA5A5_1234};
    vecs[5] = '{1'b1, 4'b0000, 32'h0000_0601, 32'h0,        32'h1122_3344, 0, 4'b1111, 32'h0000_0600, 32'h0000_0000, 1'b0, 32'h0011_2233};
    vecs[6] = '{1'b1, 4'b1111, 32'h0000_0700, 32'h0102_0304, 32'h5555_5555, 0, 4'b1111, 32'h0000_0700, 32'h0102_0304, 1'b1, 32'h0011_2233};
    vecs[7] = '{1'b1, 4'b0000, 32'h0000_0803, 32'h0,        32'hAABB_CCDD, 3, 4'b1111, 32'h0000_0800, 32'h0000_0000, 1'b0, 32'h0000_00AA};

    rst = 1'b1;
    clear_core();
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = 32'h0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst valid", 32'(bus_req_valid), 32'd0);
    chk("rst we", 32'(bus_we), 32'd0);
    chk("rst be", 32'(bus_be), 32'd0);
    chk("rst addr", bus_addr, 32'd0);
    chk("rst wdata", bus_wdata, 32'd0);
    chk("rst dr", mem_dr, 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst stall", 32'(stall), 32'd0);

    // Reset in WAIT_RSP, then a stray response.
    tick();
    mem_r = 1'b1; mem_addr = 32'h0000_0302;
    tick();
    bus_req_ready = 1'b1;
    tick();
    bus_req_ready = 1'b0;
    #1;
    chk("midrst wait stall", 32'(stall), 32'd1);
    rst = 1'b1;
    clear_core();
    tick();
    rst = 1'b0;
    bus_rsp_valid = 1'b1; bus_rdata = 32'h1234_5678;
    #1;
    chk("midrst valid", 32'(bus_req_valid), 32'd0);
    chk("midrst stall", 32'(stall), 32'd0);
    chk("midrst err", 32'(err), 32'd0);
    chk("midrst dr", mem_dr, 32'd0);
    tick();
    bus_rsp_valid = 1'b0;
    #1;
    chk("stray rsp dr", mem_dr, 32'd0);
    chk("stray rsp stall", 32'(stall), 32'd0);
    chk("stray rsp valid", 32'(bus_req_valid), 32'd0);
    chk("stray rsp err", 32'(err), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_vec(i);
    end

    run_misaligned("mis sh off3", 4'b0011, 32'h0000_0103);
    run_misaligned("mis sw off2", 4'b1111, 32'h0000_0106);
    chk("mis dr held", mem_dr, 32'h0000_00AA);

    // Response coincident with acceptance must be ignored.
    mem_r = 1'b1; mem_addr = 32'h0000_0900;
    tick();
    bus_req_ready = 1'b1; bus_rsp_valid = 1'b1; bus_rdata = 32'hBAD0_BAD0;
    tick();
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
    #1;
    chk("acc+rsp still waiting", 32'(stall), 32'd1);
    chk("acc+rsp dr held", mem_dr, 32'h0000_00AA);
    tick();
    #1;
    chk("acc+rsp wait2 stall", 32'(stall), 32'd1);
    bus_rsp_valid = 1'b1; bus_rdata = 32'h600D_600D;
    tick();
    bus_rsp_valid = 1'b0;
    #1;
    chk("acc+rsp done stall", 32'(stall), 32'd0);
    chk("acc+rsp done dr", mem_dr, 32'h600D_600D);
    clear_core();
    tick();
    #1;
    chk("final idle stall", 32'(stall), 32'd0);
    chk("final dr held", mem_dr, 32'h600D_600D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_bus_bridge.md
Name: dmem_bus_bridge

Overview:
- Sits directly downstream of the load/store memory controller, between the core's data-side strobes (mem_r, mem_w byte selector, mem_addr, mem_dw, mem_dr) and the data memory bus.
- Converts each single-cycle core request into a multi-cycle valid/ready request plus response transaction on a word-addressed bus.
- Performs byte-lane alignment on both the write and read paths.
- Stalls the core until the transaction completes, and flags misaligned accesses.

Parameters:
- ADDR_W, 32, width of core and bus address.
- TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT_RSP before abort (used only with the optional feature).

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous reset, active-high
- mem_r  input  1  core read strobe
- mem_w  input  4  core write byte selector, lane-0 based (0001, 0011 or 1111)
- mem_addr  input  ADDR_W  core byte address
- mem_dw  input  32  core write data, lane-0 based
- mem_dr  output  32  read data, right-justified to lane 0
- stall  output  1  core must hold all inputs and not advance
- err  output  1  one-cycle pulse on misaligned access or timeout
- bus_req_valid  output  1  request valid
- bus_req_ready  input  1  bus accepts request
- bus_we  output  1  1 = write, 0 = read
- bus_be  output  4  byte enables, already shifted to lanes
- bus_addr  output  ADDR_W  word address, with bits [1:0] forced to 0
- bus_wdata  output  32  write data, shifted to lanes
- bus_rsp_valid  input  1  response or write acknowledge
- bus_rdata  input  32  read data (full word)

Behaviour:
- Reset (synchronous, active-high, checked every edge):
  - state=IDLE; bus_req_valid=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0; mem_dr=0; err=0.
  - stall is combinational and therefore low in IDLE with no request.
- Request detection:
  - A request is present when mem_r=1 or mem_w≠0.
  - If both are present, the write wins.
  - off = mem_addr[1:0]; be = (write ? mem_w : 4'b0001/0011/1111 per read width).
  - Read width equals mem_w's encoding is unavailable for reads, so reads always fetch the full word with be=1111.
- Misalignment: a write is misaligned if (mem_w << off) has any bit above bit 3 set. A misaligned write issues no bus transaction, pulses err for 1 cycle, keeps stall low, and causes no state change.
- FSM:
  - IDLE: if a valid request is present, stall=1 combinationally and the FSM registers:
    - bus_addr = {mem_addr[ADDR_W-1:2], 2'b00}
    - bus_be = mem_w << off
    - bus_wdata = mem_dw << (8*off)
    - bus_we
    - the off value

    It then sets bus_req_valid=1 and moves to REQ.
  - REQ: stall=1. Hold all bus_* outputs stable. On bus_req_ready=1: drop bus_req_valid and move to WAIT_RSP.
  - WAIT_RSP: stall=1. On bus_rsp_valid=1:
    - read: mem_dr = bus_rdata >> (8*off_reg)
    - write: mem_dr unchanged

    Then move to DONE.
  - DONE: stall=0 for exactly one cycle, with mem_dr valid. The core advances on this edge; the FSM returns to IDLE without re-examining the inputs.
- Latency: minimum 3 stalled cycles (IDLE detect, REQ with ready=1, WAIT_RSP with rsp=1), followed by DONE.
- Response handling:
  - bus_rsp_valid is honoured only in WAIT_RSP; it is ignored in all other states, including a response in the same cycle as acceptance.
  - Any stray response arriving after a reset is ignored.
- mem_dr holds its last value between transactions.
- Reset mid-transaction: the FSM returns to IDLE immediately and drops bus_req_valid; no err pulse is generated.

Optional Feature:
- Macro DMEM_BRIDGE_TIMEOUT_EN.
- When defined:
  - An 8+ bit counter clears on entry to WAIT_RSP and increments each WAIT_RSP cycle.
  - If it reaches TIMEOUT_CYCLES without a response, the bridge sets mem_dr=0, pulses err for 1 cycle, and moves to DONE.
  - A response arriving on the same cycle as the limit wins, with no err.
- When undefined: there is no counter, WAIT_RSP waits indefinitely, and err reports misalignment only.

Test Plan:
- Aligned SW: mem_w=1111, addr=0x100, dw=0xDEADBEEF, ready=1 immediately, rsp 1 cycle later -> bus_addr=0x100, be=1111, wdata=0xDEADBEEF, stall high 3 cycles, then DONE, err=0.
- SB at offset 3: mem_w=0001, addr=0x203, dw=0x000000AB -> bus_addr=0x200, be=1000, wdata=0xAB000000.
- Read at offset 2: addr=0x302, rdata=0x12345678, ready delayed 4 cycles -> bus_req_valid held 5 cycles with stable outputs; mem_dr=0x00001234 in DONE.
- Misaligned SH at offset 3: mem_w=0011, addr=0x103 -> no bus_req_valid, err=1 for 1 cycle, stall=0.
- Reset asserted in WAIT_RSP, followed by rsp_valid=1 -> state IDLE, bus_req_valid=0, mem_dr unchanged from reset value 0, err=0.
- With DMEM_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=4, read with no rsp -> after 4 WAIT_RSP cycles err=1, mem_dr=0, stall drops; repeat with rsp on the 4th cycle -> err=0 and data returned.
